// File: rtl/io_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// io_bus_arbiter_if
// Purpose : Bundles the CPU port, the secondary-master request/response
//           ports and the shared 16-bit external I/O bus of io_bus_arbiter.
// Modports:
//   slave  - arbiter side: consumes CPU/master requests and bus_rdata,
//            drives grants, acks, read data and the shared bus.
//   master - environment side: the CPU, the NM secondary masters and the
//            bus device (the mirror image of slave).
// Signals : cpu_acc/cpu_we/cpu_addr/cpu_wdata/cpu_rdata  CPU access
//           req/m_we/m_addr/m_wdata (master i at [16i+15:16i])
//           gnt/ack/m_rdata/err                       master response
//           bus_addr/bus_wdata/bus_we/bus_oe/bus_rdata shared bus
// ---------------------------------------------------------------------------
interface io_bus_arbiter_if #(
  parameter int NM = 2
);
  logic                cpu_acc;
  logic                cpu_we;
  logic [15:0]         cpu_addr;
  logic [15:0]         cpu_wdata;
  logic [15:0]         cpu_rdata;
  logic [NM-1:0]       req;
  logic [NM-1:0]       m_we;
  logic [16*NM-1:0]    m_addr;
  logic [16*NM-1:0]    m_wdata;
  logic [NM-1:0]       gnt;
  logic [NM-1:0]       ack;
  logic [15:0]         m_rdata;
  logic                err;
  logic [15:0]         bus_addr;
  logic [15:0]         bus_wdata;
  logic                bus_we;
  logic                bus_oe;
  logic [15:0]         bus_rdata;

  modport slave (
    input  cpu_acc, cpu_we, cpu_addr, cpu_wdata,
    input  req, m_we, m_addr, m_wdata,
    input  bus_rdata,
    output cpu_rdata, gnt, ack, m_rdata, err,
    output bus_addr, bus_wdata, bus_we, bus_oe
  );

  modport master (
    output cpu_acc, cpu_we, cpu_addr, cpu_wdata,
    output req, m_we, m_addr, m_wdata,
    output bus_rdata,
    input  cpu_rdata, gnt, ack, m_rdata, err,
    input  bus_addr, bus_wdata, bus_we, bus_oe
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// ---------------------------------------------------------------------------
// io_bus_arbiter
// Purpose : Shares the CPU's 16-bit external I/O bus with NM secondary
//           masters. The CPU always wins and is never stalled; secondaries
//           get round-robin single-beat transactions in CPU-free cycles.
// Ports   : i_clk    clock, rising edge
//           i_reset  synchronous, active-high reset
//           io_bus   io_bus_arbiter_if.slave (CPU, masters, shared bus)
// Params  : NM       number of secondary masters (1..8)
//           TIMEOUT  blocked cycles before a granted transaction aborts
// Option  : define IOARB_TIMEOUT_EN to enable the blocked-transaction abort
//           (ack with err=1); without it err stays 0 and ISSUE waits forever.
// ---------------------------------------------------------------------------
module io_bus_arbiter #(
  parameter int NM      = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  io_bus_arbiter_if.slave   io_bus
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t          r_state;
  logic [NM-1:0]   r_gnt;
  logic [NM-1:0]   r_ack;
  logic            r_err;
  logic [15:0]     r_m_rdata;
  logic [PW-1:0]   r_rr_ptr;
  logic [3:0]      r_wait_cnt;
  logic [PW-1:0]   r_win;

  state_t          w_state_nxt;
  logic [NM-1:0]   w_gnt_nxt;
  logic [NM-1:0]   w_ack_nxt;
  logic            w_err_nxt;
  logic [15:0]     w_m_rdata_nxt;
  logic [PW-1:0]   w_rr_ptr_nxt;
  logic [3:0]      w_wait_cnt_nxt;
  logic [PW-1:0]   w_win_nxt;

  logic [PW-1:0]   w_pick;
  logic [NM-1:0]   w_pick_oh;
  logic            w_tmo_hit;

`ifdef IOARB_TIMEOUT_EN
  // Abort fires on the TIMEOUT-th consecutive blocked cycle.
  assign w_tmo_hit = (r_wait_cnt == 4'(TIMEOUT - 1));
`else
  // Timeout disabled: abort never fires.
  assign w_tmo_hit = 1'b0 && (TIMEOUT > 0);
`endif

  // Round-robin winner: first requester after the last served master.
  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    w_pick    = r_rr_ptr;
    w_pick_oh = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NM; k++) begin
      idx = PW'((int'(r_rr_ptr) + k) % NM);
      if (!found && io_bus.req[idx]) begin
        w_pick = idx;
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
    w_pick_oh[w_pick] = 1'b1;
  end

  // Next-state and next-output logic of the grant FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_ack_nxt      = r_ack;
    w_err_nxt      = r_err;
    w_m_rdata_nxt  = r_m_rdata;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_wait_cnt_nxt = r_wait_cnt;
    w_win_nxt      = r_win;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.req != '0) begin
          w_win_nxt   = w_pick;
          w_gnt_nxt   = w_pick_oh;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // r_gnt is already onehot(winner), so it doubles as the ack mask.
        if (!io_bus.cpu_acc) begin
          w_m_rdata_nxt = io_bus.bus_rdata;
          w_ack_nxt     = r_gnt;
          w_err_nxt     = 1'b0;
          w_gnt_nxt     = '0;
          w_rr_ptr_nxt  = r_win;
          w_state_nxt   = ST_DONE;
        end else if (w_tmo_hit) begin
          w_ack_nxt     = r_gnt;
          w_err_nxt     = 1'b1;
          w_gnt_nxt     = '0;
          w_rr_ptr_nxt  = r_win;
          w_state_nxt   = ST_DONE;
        end else begin
          w_wait_cnt_nxt = (r_wait_cnt == 4'hF) ? 4'hF : (r_wait_cnt + 4'h1);
        end
      end
      ST_DONE: begin
        w_ack_nxt      = '0;
        w_err_nxt      = 1'b0;
        w_wait_cnt_nxt = 4'h0;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_gnt_nxt      = '0;
        w_ack_nxt      = '0;
        w_err_nxt      = 1'b0;
        w_wait_cnt_nxt = 4'h0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_m_rdata  <= 16'h0000;
      r_rr_ptr   <= PW'(NM - 1);
      r_wait_cnt <= 4'h0;
      r_win      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_m_rdata  <= w_m_rdata_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_win      <= w_win_nxt;
    end
  end

  // Shared bus mux: CPU first, then the granted master, else released.
  always_comb begin
    io_bus.bus_addr  = 16'h0000;
    io_bus.bus_wdata = 16'h0000;
    io_bus.bus_we    = 1'b0;
    io_bus.bus_oe    = 1'b0;
    if (io_bus.cpu_acc) begin
      io_bus.bus_addr  = io_bus.cpu_addr;
      io_bus.bus_wdata = io_bus.cpu_wdata;
      io_bus.bus_we    = io_bus.cpu_we;
      io_bus.bus_oe    = 1'b1;
    end else if (r_state == ST_ISSUE) begin
      io_bus.bus_addr  = io_bus.m_addr[16*int'(r_win) +: 16];
      io_bus.bus_wdata = io_bus.m_wdata[16*int'(r_win) +: 16];
      io_bus.bus_we    = io_bus.m_we[r_win];
      io_bus.bus_oe    = 1'b1;
    end else begin
      io_bus.bus_oe    = 1'b0;
    end
  end

  assign io_bus.cpu_rdata = io_bus.bus_rdata;
  assign io_bus.gnt       = r_gnt;
  assign io_bus.ack       = r_ack;
  assign io_bus.err       = r_err;
  assign io_bus.m_rdata   = r_m_rdata;

endmodule
